// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - requester, ALU and result signals shared by alu_arb and its environment
interface alu_arb_if;
  logic        r0_req;
  logic [9:0]  r0_op;
  logic [15:0] r0_a;
  logic [15:0] r0_b;
  logic [7:0]  r0_ps;
  logic        r0_ack;

  logic        r1_req;
  logic [9:0]  r1_op;
  logic [15:0] r1_a;
  logic [15:0] r1_b;
  logic [7:0]  r1_ps;
  logic        r1_ack;

  logic [9:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_ps;
  logic [15:0] alu_d;
  logic [7:0]  alu_psr;

  logic [15:0] res_d;
  logic [7:0]  res_psr;
  logic        res_valid0;
  logic        res_valid1;

  modport slave (
    input  r0_req, r0_op, r0_a, r0_b, r0_ps,
    input  r1_req, r1_op, r1_a, r1_b, r1_ps,
    input  alu_d, alu_psr,
    output r0_ack, r1_ack,
    output alu_op, alu_a, alu_b, alu_ps,
    output res_d, res_psr, res_valid0, res_valid1
  );

  modport master (
    output r0_req, r0_op, r0_a, r0_b, r0_ps,
    output r1_req, r1_op, r1_a, r1_b, r1_ps,
    output alu_d, alu_psr,
    input  r0_ack, r1_ack,
    input  alu_op, alu_a, alu_b, alu_ps,
    input  res_d, res_psr, res_valid0, res_valid1
  );
endinterface

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-requester ALU arbiter with operand and result pipeline stages
// ALU_ARB_RR_EN: round-robin on conflicts; undefined gives fixed priority to requester 0.
module alu_arb (
  input  logic      clk,
  input  logic      reset,
  alu_arb_if.slave  bus
);

  logic        gnt0;
  logic        gnt1;

  logic        last_grant_q, last_grant_d;
  logic        s1_valid_q,   s1_valid_d;
  logic        s1_owner_q,   s1_owner_d;
  logic [9:0]  op_q,         op_d;
  logic [15:0] a_q,          a_d;
  logic [15:0] b_q,          b_d;
  logic [7:0]  ps_q,         ps_d;

  logic [15:0] res_d_q,      res_d_d;
  logic [7:0]  res_psr_q,    res_psr_d;
  logic        res_v0_q,     res_v0_d;
  logic        res_v1_q,     res_v1_d;

  // Grants are suppressed while reset is high so nothing enters the pipe.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (bus.r0_req && bus.r1_req) begin
`ifdef ALU_ARB_RR_EN
        if (last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = bus.r0_req;
        gnt1 = bus.r1_req;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    s1_valid_d   = gnt0 | gnt1;
    s1_owner_d   = s1_owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    ps_d         = ps_q;
    res_d_d      = res_d_q;
    res_psr_d    = res_psr_q;
    res_v0_d     = 1'b0;
    res_v1_d     = 1'b0;

    if (gnt1) begin
      last_grant_d = 1'b1;
      s1_owner_d   = 1'b1;
      op_d         = bus.r1_op;
      a_d          = bus.r1_a;
      b_d          = bus.r1_b;
      ps_d         = bus.r1_ps;
    end else if (gnt0) begin
      last_grant_d = 1'b0;
      s1_owner_d   = 1'b0;
      op_d         = bus.r0_op;
      a_d          = bus.r0_a;
      b_d          = bus.r0_b;
      ps_d         = bus.r0_ps;
    end

    // The owner tag captured with the operands steers the result, not the current grant.
    if (s1_valid_q) begin
      res_d_d   = bus.alu_d;
      res_psr_d = bus.alu_psr;
      res_v0_d  = ~s1_owner_q;
      res_v1_d  = s1_owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ps_q         <= '0;
      res_d_q      <= '0;
      res_psr_q    <= '0;
      res_v0_q     <= 1'b0;
      res_v1_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_owner_q   <= s1_owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ps_q         <= ps_d;
      res_d_q      <= res_d_d;
      res_psr_q    <= res_psr_d;
      res_v0_q     <= res_v0_d;
      res_v1_q     <= res_v1_d;
    end
  end

  assign bus.r0_ack     = gnt0;
  assign bus.r1_ack     = gnt1;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_ps     = ps_q;
  assign bus.res_d      = res_d_q;
  assign bus.res_psr    = res_psr_q;
  assign bus.res_valid0 = res_v0_q;
  assign bus.res_valid1 = res_v1_q;

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 r0_req  input  1  requester 0 (execution unit) request; held until acked.
REQ-004 r0_op / r0_a / r0_b / r0_ps  input  10/16/16/8  requester 0 opcode, source, destination, PS; stable while r0_req high.
REQ-005 r0_ack  output  1  combinational; high in the cycle requester 0's operands are accepted.
REQ-006 r1_req, r1_op, r1_a, r1_b, r1_ps, r1_ack  same widths  requester 1 (address unit, typically INC2/DEC2), same rules.
REQ-007 alu_op / alu_a / alu_b / alu_ps  output  10/16/16/8  registered operands driven to the ALU.
REQ-008 alu_d / alu_psr  input  16/8  combinational ALU result and PS result.
REQ-009 res_d / res_psr  output  16/8  registered result, held until the next result.
REQ-010 res_valid0 / res_valid1  output  1 each  one-cycle pulse marking res_d/res_psr as belonging to requester 0/1.

Function
REQ-011 Two-stage pipeline: stage 1 (operand registers + owner tag + s1_valid), stage 2 (result registers + res_valid pulses).
REQ-012 Accept in cycle T: rNack high in T; operands latched to alu_* at end of T; ALU result captured at end of T+1; res_validN high in T+2 only.
REQ-013 Throughput one op per cycle; accept and capture occur in the same cycle without a bubble.
REQ-014 At most one ack per cycle; ack never asserted for a requester whose req is low.
REQ-015 Only req high -> that requester acked that cycle.
REQ-016 Both req high -> winner per REQ-024/025; loser's req stays high and is acked in a later cycle.
REQ-017 No ack in a cycle -> s1_valid cleared at the edge; alu_op/alu_a/alu_b/alu_ps keep their previous values.
REQ-018 s1_valid low in a cycle -> no res_valid pulse next cycle; res_d/res_psr unchanged.
REQ-019 res_valid0 and res_valid1 never high together.
REQ-020 Owner tag travels with the operands; result routing is unaffected by later arbitration.
REQ-021 Pointer last_grant (1 bit) updates only on an ack, to the acked requester index.

Reset
REQ-022 During reset: r0_ack=0, r1_ack=0, alu_op=0, alu_a=0, alu_b=0, alu_ps=0, res_d=0, res_psr=0, res_valid0=0, res_valid1=0, s1_valid=0, last_grant=1.
REQ-023 Reset in a cycle holding in-flight ops discards them; no res_valid pulse is produced for them after reset deasserts.

Configuration
REQ-024 ALU_ARB_RR_EN defined: round-robin; on conflict grant the requester not equal to last_grant.
REQ-025 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins conflicts; last_grant is still maintained but unused.

Verification
REQ-026 r0 alone, op=ADD a=0x0001 b=0x0002 ps=0x00 in cycle 1 -> r0_ack in cycle 1; res_valid0 in cycle 3; res_d=0x0003, res_psr=0x00.
REQ-027 Both req held 4 cycles, r0 op=INC b=0x7FFF, r1 op=INC2 b=0x1000; RR build -> acks r0,r1,r0,r1 and results 0x8000 (psr=0x0A), 0x1002 alternating. Fixed build -> r0 acked 4 times, r1_ack stays 0.
REQ-028 r1 back-to-back 3 ops (DEC2 b=0x0004, 0x0002, 0x0000) -> res_valid1 high 3 consecutive cycles with 0x0002, 0x0000, 0xFFFE.
REQ-029 r0 ack in cycle 1, reset high in cycle 2 -> no res_valid in cycles 3-4; all outputs 0 after reset.
REQ-030 Single op, then no requests 5 cycles -> exactly one res_valid pulse; res_d held for the 5 idle cycles.
